// File: rtl/hamming_pkg.sv
// Shared types and helpers for the SECDED serial receiver: parity-width
// calculation, Hamming position helpers, decode outcome and FSM state enums.
package hamming_pkg;

  localparam int MAX_DATA_W = 57;
  localparam int MAX_POS    = 64;

  typedef enum logic [1:0] {
    CLEAN   = 2'd0,
    SINGLE  = 2'd1,
    P0_ONLY = 2'd2,
    DOUBLE  = 2'd3
  } dec_outcome_e;

  typedef enum logic {
    RECV   = 1'b0,
    DECODE = 1'b1
  } rx_state_e;

  // Smallest r with 2^r >= data_w + r + 1; seven steps cover data_w up to 57
  function automatic int calc_par_w(input int data_w);
    int r;
    r = 1;
    for (int i = 0; i < 7; i++) begin
      if ((1 << r) < (data_w + r + 1)) r = r + 1;
    end
    return r;
  endfunction

  // Parity bits live at the power-of-two Hamming positions
  function automatic logic is_pow2(input int pos);
    return (pos > 0) && ((pos & (pos - 1)) == 0);
  endfunction

  // Hamming position of the k-th data bit (k = 0 is the lowest data position)
  function automatic int data_pos(input int k);
    int cnt;
    int pos;
    cnt = 0;
    pos = 0;
    for (int p = 1; p <= MAX_POS; p++) begin
      if (!is_pow2(p)) begin
        if ((cnt == k) && (pos == 0)) pos = p;
        cnt = cnt + 1;
      end
    end
    return pos;
  endfunction

endpackage

// File: rtl/hamming_secded_dec.sv
// Combinational SECDED decode of one codeword: cw[p] holds Hamming position p
// (1..N) and cw[0] holds the overall parity bit p0.
module hamming_secded_dec
  import hamming_pkg::*;
#(
  parameter  int DATA_W = 4,
  localparam int PAR_W  = calc_par_w(DATA_W),
  localparam int N      = DATA_W + PAR_W,
  localparam int CW_W   = N + 1
) (
  input  logic [CW_W-1:0]   cw,
  output logic [DATA_W-1:0] data,
  output logic [PAR_W-1:0]  syndrome,
  output dec_outcome_e      outcome
);

  logic [PAR_W-1:0] s;
  logic             pf;
  logic [CW_W-1:0]  fixed;

  // Syndrome and overall parity, classification, single-bit fix, data extraction
  always_comb begin
    s       = '0;
    pf      = ^cw;
    fixed   = cw;
    outcome = CLEAN;
    for (int p = 1; p <= N; p++) begin
      if (cw[p]) s = s ^ PAR_W'(p);
    end
    if (pf) begin
      if (s == '0) begin
        outcome = P0_ONLY;
      end else if (int'(s) <= N) begin
        outcome = SINGLE;
        for (int p = 1; p <= N; p++) begin
          if (PAR_W'(p) == s) fixed[p] = ~cw[p];
        end
      end else begin
        outcome = DOUBLE;
      end
    end else if (s != '0) begin
      outcome = DOUBLE;
    end
    data = '0;
    for (int k = 0; k < DATA_W; k++) begin
      data[DATA_W-1-k] = fixed[data_pos(k)];
    end
    syndrome = s;
  end

endmodule

// File: rtl/hamming_secded_rx.sv
// Serial Hamming SECDED receiver: bit capture with resync, a RECV/DECODE FSM,
// registered decode results with a one-cycle valid pulse, saturating counters.
module hamming_secded_rx
  import hamming_pkg::*;
#(
  parameter  int DATA_W = 4,
  parameter  int CNT_W  = 8,
  localparam int PAR_W  = calc_par_w(DATA_W),
  localparam int N      = DATA_W + PAR_W,
  localparam int CW_W   = N + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_in,
  input  logic              strobe_in,
  input  logic              sync_in,
  input  logic              cnt_clr,
  output logic [DATA_W-1:0] data_out,
  output logic              out_valid,
  output logic              err_corrected,
  output logic              err_double,
  output logic [PAR_W-1:0]  syndrome,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  dbl_cnt
);

  localparam int BC_W = $clog2(CW_W);

  rx_state_e         state_q, state_d;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CW_W-1:0]   shift_q, shift_d;
  logic [CW_W-1:0]   dec_q, dec_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              out_valid_q, out_valid_d;
  logic              err_corrected_q, err_corrected_d;
  logic              err_double_q, err_double_d;
  logic [PAR_W-1:0]  syndrome_q, syndrome_d;
  logic [CNT_W-1:0]  corr_cnt_q, corr_cnt_d;
  logic [CNT_W-1:0]  dbl_cnt_q, dbl_cnt_d;
  logic              frame_done;

  logic [DATA_W-1:0] dec_data;
  logic [PAR_W-1:0]  dec_syndrome;
  dec_outcome_e      dec_outcome;
  logic              flag_corr;
  logic              flag_dbl;

  hamming_secded_dec #(
    .DATA_W (DATA_W)
  ) u_dec (
    .cw       (dec_q),
    .data     (dec_data),
    .syndrome (dec_syndrome),
    .outcome  (dec_outcome)
  );

  assign flag_corr = (dec_outcome == SINGLE) || (dec_outcome == P0_ONLY);
  assign flag_dbl  = (dec_outcome == DOUBLE);

  // Capture, FSM next state, output register and counter next-state logic
  always_comb begin
    shift_d         = shift_q;
    bit_cnt_d       = bit_cnt_q;
    dec_d           = dec_q;
    frame_done      = 1'b0;
    data_out_d      = data_out_q;
    err_corrected_d = err_corrected_q;
    err_double_d    = err_double_q;
    syndrome_d      = syndrome_q;
    corr_cnt_d      = corr_cnt_q;
    dbl_cnt_d       = dbl_cnt_q;

    if (strobe_in) shift_d = {shift_q[CW_W-2:0], data_in};
    if (sync_in) begin
      bit_cnt_d = strobe_in ? BC_W'(1) : '0;
    end else if (strobe_in) begin
      if (bit_cnt_q == BC_W'(CW_W - 1)) begin
        bit_cnt_d  = '0;
        frame_done = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end

    // First received bit (position 1) ends up at the top of the shift register
    if (frame_done) begin
      for (int p = 1; p <= N; p++) begin
        dec_d[p] = shift_d[CW_W-p];
      end
      dec_d[0] = shift_d[0];
    end

    state_d     = frame_done ? DECODE : RECV;
    out_valid_d = (state_q == DECODE);

    if (state_q == DECODE) begin
      data_out_d      = dec_data;
      err_corrected_d = flag_corr;
      err_double_d    = flag_dbl;
      syndrome_d      = dec_syndrome;
    end

    if (cnt_clr) begin
      corr_cnt_d = '0;
      dbl_cnt_d  = '0;
    end else if (state_q == DECODE) begin
      if (flag_corr && (corr_cnt_q != '1)) corr_cnt_d = corr_cnt_q + 1'b1;
      if (flag_dbl && (dbl_cnt_q != '1))   dbl_cnt_d  = dbl_cnt_q + 1'b1;
    end
  end

  // All state, including the FSM, registered with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q         <= RECV;
      bit_cnt_q       <= '0;
      shift_q         <= '0;
      dec_q           <= '0;
      data_out_q      <= '0;
      out_valid_q     <= 1'b0;
      err_corrected_q <= 1'b0;
      err_double_q    <= 1'b0;
      syndrome_q      <= '0;
      corr_cnt_q      <= '0;
      dbl_cnt_q       <= '0;
    end else begin
      state_q         <= state_d;
      bit_cnt_q       <= bit_cnt_d;
      shift_q         <= shift_d;
      dec_q           <= dec_d;
      data_out_q      <= data_out_d;
      out_valid_q     <= out_valid_d;
      err_corrected_q <= err_corrected_d;
      err_double_q    <= err_double_d;
      syndrome_q      <= syndrome_d;
      corr_cnt_q      <= corr_cnt_d;
      dbl_cnt_q       <= dbl_cnt_d;
    end
  end

  assign data_out      = data_out_q;
  assign out_valid     = out_valid_q;
  assign err_corrected = err_corrected_q;
  assign err_double    = err_double_q;
  assign syndrome      = syndrome_q;
  assign corr_cnt      = corr_cnt_q;
  assign dbl_cnt       = dbl_cnt_q;

endmodule

// File: tb/tb_hamming_secded_rx.sv
// Bench for hamming_secded_rx: a DATA_W=4 instance driven from a vector table
// plus resync/reset sequences, and a DATA_W=11, CNT_W=2 instance for counters.
module tb_hamming_secded_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        d4_data, d4_strobe, d4_sync, d4_clr;
  logic [3:0]  d4_out;
  logic        d4_valid, d4_corr, d4_dbl;
  logic [2:0]  d4_syn;
  logic [7:0]  d4_ccnt, d4_dcnt;

  logic        d11_data, d11_strobe, d11_sync, d11_clr;
  logic [10:0] d11_out;
  logic        d11_valid, d11_corr, d11_dbl;
  logic [3:0]  d11_syn;
  logic [1:0]  d11_ccnt, d11_dcnt;

  hamming_secded_rx #(.DATA_W(4), .CNT_W(8)) dut4 (
    .clk           (clk),
    .rst           (rst),
    .data_in       (d4_data),
    .strobe_in     (d4_strobe),
    .sync_in       (d4_sync),
    .cnt_clr       (d4_clr),
    .data_out      (d4_out),
    .out_valid     (d4_valid),
    .err_corrected (d4_corr),
    .err_double    (d4_dbl),
    .syndrome      (d4_syn),
    .corr_cnt      (d4_ccnt),
    .dbl_cnt       (d4_dcnt)
  );

  hamming_secded_rx #(.DATA_W(11), .CNT_W(2)) dut11 (
    .clk           (clk),
    .rst           (rst),
    .data_in       (d11_data),
    .strobe_in     (d11_strobe),
    .sync_in       (d11_sync),
    .cnt_clr       (d11_clr),
    .data_out      (d11_out),
    .out_valid     (d11_valid),
    .err_corrected (d11_corr),
    .err_double    (d11_dbl),
    .syndrome      (d11_syn),
    .corr_cnt      (d11_ccnt),
    .dbl_cnt       (d11_dcnt)
  );

  typedef struct {
    logic [7:0] frame;
    logic [3:0] data;
    logic       corr;
    logic       dbl;
    logic [2:0] syn;
  } vec4_t;

  vec4_t vecs [9];
  int tests_run    = 0;
  int tests_failed = 0;
  int pulses4      = 0;
  int exp_c4       = 0;
  int exp_d4       = 0;
  int base;

  // Count valid pulses of the 4-bit instance using the pre-edge value
  always @(posedge clk) begin
    if (d4_valid) pulses4 <= pulses4 + 1;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Send a full 8-bit frame (MSB = position 1, LSB = p0) and step to the valid cycle
  task automatic applyStimulus(input string name, input logic [7:0] frame);
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk);
      d4_data   = frame[i];
      d4_strobe = 1'b1;
    end
    @(negedge clk);
    d4_strobe = 1'b0;
    checkOutput({name, "_valid_early"}, 64'(d4_valid), 64'd0);
    @(negedge clk);
  endtask

  // Send a 16-bit frame to the 11-bit instance, optionally clearing in the decode cycle
  task automatic applyStimulus11(input string name, input logic [15:0] frame, input logic clr);
    for (int i = 15; i >= 0; i--) begin
      @(negedge clk);
      d11_data   = frame[i];
      d11_strobe = 1'b1;
    end
    @(negedge clk);
    d11_strobe = 1'b0;
    d11_clr    = clr;
    checkOutput({name, "_valid_early"}, 64'(d11_valid), 64'd0);
    @(negedge clk);
    d11_clr = 1'b0;
  endtask

  task automatic check4(input string name, input logic [3:0] data, input logic corr,
                        input logic dbl, input logic [2:0] syn);
    if (corr) exp_c4++;
    if (dbl)  exp_d4++;
    checkOutput({name, "_valid"}, 64'(d4_valid), 64'd1);
    checkOutput({name, "_data"},  64'(d4_out),   64'(data));
    checkOutput({name, "_corr"},  64'(d4_corr),  64'(corr));
    checkOutput({name, "_dbl"},   64'(d4_dbl),   64'(dbl));
    checkOutput({name, "_syn"},   64'(d4_syn),   64'(syn));
    checkOutput({name, "_ccnt"},  64'(d4_ccnt),  64'(exp_c4));
    checkOutput({name, "_dcnt"},  64'(d4_dcnt),  64'(exp_d4));
    @(negedge clk);
    checkOutput({name, "_valid_pulse"}, 64'(d4_valid), 64'd0);
  endtask

  task automatic check11(input string name, input logic [10:0] data, input logic corr,
                         input logic dbl, input logic [3:0] syn, input logic [1:0] ccnt,
                         input logic [1:0] dcnt);
    checkOutput({name, "_valid"}, 64'(d11_valid), 64'd1);
    checkOutput({name, "_data"},  64'(d11_out),   64'(data));
    checkOutput({name, "_corr"},  64'(d11_corr),  64'(corr));
    checkOutput({name, "_dbl"},   64'(d11_dbl),   64'(dbl));
    checkOutput({name, "_syn"},   64'(d11_syn),   64'(syn));
    checkOutput({name, "_ccnt"},  64'(d11_ccnt),  64'(ccnt));
    checkOutput({name, "_dcnt"},  64'(d11_dcnt),  64'(dcnt));
    @(negedge clk);
    checkOutput({name, "_valid_pulse"}, 64'(d11_valid), 64'd0);
  endtask

  // All-ones 16-bit frame is a clean codeword of data 7FF; flip Hamming position k
  function automatic logic [15:0] flip11(input int k);
    logic [15:0] f;
    f = 16'hFFFF;
    f[16-k] = ~f[16-k];
    return f;
  endfunction

  initial begin
    vecs[0] = '{8'b01100110, 4'b1011, 1'b0, 1'b0, 3'd0};
    vecs[1] = '{8'b01101110, 4'b1011, 1'b1, 1'b0, 3'd5};
    vecs[2] = '{8'b00100010, 4'b1001, 1'b0, 1'b1, 3'd4};
    vecs[3] = '{8'b01100111, 4'b1011, 1'b1, 1'b0, 3'd0};
    vecs[4] = '{8'b00000000, 4'b0000, 1'b0, 1'b0, 3'd0};
    vecs[5] = '{8'b01000110, 4'b1011, 1'b1, 1'b0, 3'd3};
    vecs[6] = '{8'b11100110, 4'b1011, 1'b1, 1'b0, 3'd1};
    vecs[7] = '{8'b11001100, 4'b0110, 1'b0, 1'b0, 3'd0};
    vecs[8] = '{8'b01001110, 4'b0111, 1'b0, 1'b1, 3'd6};

    rst = 1'b0;
    d4_data = 1'b0; d4_strobe = 1'b0; d4_sync = 1'b0; d4_clr = 1'b0;
    d11_data = 1'b0; d11_strobe = 1'b0; d11_sync = 1'b0; d11_clr = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_valid", 64'(d4_valid), 64'd0);
    checkOutput("rst_data",  64'(d4_out),   64'd0);
    checkOutput("rst_flags", 64'({d4_corr, d4_dbl}), 64'd0);
    checkOutput("rst_syn",   64'(d4_syn),   64'd0);
    checkOutput("rst_cnts",  64'({d4_ccnt, d4_dcnt}), 64'd0);
    rst = 1'b1;

    // Table-driven single frames on the 4-bit instance
    for (int i = 0; i < 9; i++) begin
      applyStimulus($sformatf("v%0d", i), vecs[i].frame);
      check4($sformatf("v%0d", i), vecs[i].data, vecs[i].corr, vecs[i].dbl, vecs[i].syn);
    end

    // Two back-to-back frames with strobe held high, then reset 3 bits into a third
    base = pulses4;
    for (int f = 0; f < 2; f++) begin
      for (int i = 7; i >= 0; i--) begin
        @(negedge clk);
        d4_data   = vecs[f].frame[i];
        d4_strobe = 1'b1;
      end
    end
    for (int i = 7; i >= 5; i--) begin
      @(negedge clk);
      d4_data = vecs[0].frame[i];
    end
    @(negedge clk);
    checkOutput("b2b_held_data", 64'(d4_out),  64'hB);
    checkOutput("b2b_held_corr", 64'(d4_corr), 64'd1);
    checkOutput("b2b_held_syn",  64'(d4_syn),  64'd5);
    d4_strobe = 1'b0;
    rst       = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("b2b_pulses", 64'(pulses4 - base), 64'd2);
    checkOutput("b2b_rst_valid", 64'(d4_valid), 64'd0);
    checkOutput("b2b_rst_data",  64'(d4_out),   64'd0);
    checkOutput("b2b_rst_flags", 64'({d4_corr, d4_dbl}), 64'd0);
    checkOutput("b2b_rst_syn",   64'(d4_syn),   64'd0);
    checkOutput("b2b_rst_cnts",  64'({d4_ccnt, d4_dcnt}), 64'd0);
    rst    = 1'b1;
    exp_c4 = 0;
    exp_d4 = 0;
    applyStimulus("post_rst", vecs[0].frame);
    check4("post_rst", 4'b1011, 1'b0, 1'b0, 3'd0);

    // Resync with a strobe in the same cycle: that bit becomes bit 0 of the new frame
    base = pulses4;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      d4_data   = 1'b1;
      d4_strobe = 1'b1;
    end
    @(negedge clk);
    d4_strobe = 1'b0;
    @(negedge clk);
    d4_sync   = 1'b1;
    d4_strobe = 1'b1;
    d4_data   = vecs[7].frame[7];
    for (int i = 6; i >= 0; i--) begin
      @(negedge clk);
      d4_sync = 1'b0;
      d4_data = vecs[7].frame[i];
    end
    @(negedge clk);
    d4_strobe = 1'b0;
    checkOutput("sync_strobe_valid_early", 64'(d4_valid), 64'd0);
    @(negedge clk);
    check4("sync_strobe", 4'b0110, 1'b0, 1'b0, 3'd0);
    checkOutput("sync_strobe_pulses", 64'(pulses4 - base), 64'd1);

    // Resync alone discards a partial frame
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      d4_data   = 1'b1;
      d4_strobe = 1'b1;
    end
    @(negedge clk);
    d4_strobe = 1'b0;
    d4_sync   = 1'b1;
    @(negedge clk);
    d4_sync = 1'b0;
    applyStimulus("sync_only", vecs[1].frame);
    check4("sync_only", 4'b1011, 1'b1, 1'b0, 3'd5);

    // 11-bit instance: single errors with a clear in the third decode cycle
    applyStimulus11("w1", flip11(3), 1'b0);
    check11("w1", 11'h7FF, 1'b1, 1'b0, 4'd3, 2'd1, 2'd0);
    applyStimulus11("w2", flip11(8), 1'b0);
    check11("w2", 11'h7FF, 1'b1, 1'b0, 4'd8, 2'd2, 2'd0);
    applyStimulus11("w3", flip11(15), 1'b1);
    check11("w3", 11'h7FF, 1'b1, 1'b0, 4'd15, 2'd0, 2'd0);
    applyStimulus11("w4", flip11(1), 1'b0);
    check11("w4", 11'h7FF, 1'b1, 1'b0, 4'd1, 2'd1, 2'd0);
    applyStimulus11("w5", flip11(12), 1'b0);
    check11("w5", 11'h7FF, 1'b1, 1'b0, 4'd12, 2'd2, 2'd0);

    // Idle clear, then saturation at 3
    @(negedge clk);
    d11_clr = 1'b1;
    @(negedge clk);
    d11_clr = 1'b0;
    checkOutput("w_idle_clr", 64'(d11_ccnt), 64'd0);
    applyStimulus11("s1", flip11(5), 1'b0);
    check11("s1", 11'h7FF, 1'b1, 1'b0, 4'd5, 2'd1, 2'd0);
    applyStimulus11("s2", 16'hFFFE, 1'b0);
    check11("s2", 11'h7FF, 1'b1, 1'b0, 4'd0, 2'd2, 2'd0);
    applyStimulus11("s3", flip11(9), 1'b0);
    check11("s3", 11'h7FF, 1'b1, 1'b0, 4'd9, 2'd3, 2'd0);
    applyStimulus11("s4", flip11(2), 1'b0);
    check11("s4", 11'h7FF, 1'b1, 1'b0, 4'd2, 2'd3, 2'd0);
    applyStimulus11("s5", flip11(14), 1'b0);
    check11("s5", 11'h7FF, 1'b1, 1'b0, 4'd14, 2'd3, 2'd0);
    applyStimulus11("d1", flip11(4) ^ flip11(10) ^ 16'hFFFF, 1'b0);
    check11("d1", 11'h7DF, 1'b0, 1'b1, 4'd14, 2'd3, 2'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
